// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding byte, padder state encoding.
// Used by the message padder and the compression-core wrapper.
package sha256_pkg;

    localparam int         BLOCK_WORDS = 16;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    // Padder state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_EMIT      = 3'd2,
        ST_PADBLK    = 3'd3,
        ST_EMIT_LAST = 3'd4
    } pad_state_e;

    // Byte counts above four describe a full word
    function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word shaper: keeps the first nbytes bytes (big-endian order), zeroes
// the rest and drops the 0x80 terminator into the first unused byte.
// A full word (nbytes=4) passes through unchanged.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] word_o
);

    // Per-byte select: message byte, terminator, or zero
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes_i) begin
                word_o[31-8*b -: 8] = word_i[31-8*b -: 8];
            end else if (3'(b) == nbytes_i) begin
                word_o[31-8*b -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: assembles 32-bit words into 512-bit blocks, appends
// the 0x80 terminator, zero fill and 64-bit big-endian bit length, and flags
// the first and last block of each message. Single-entry output buffer.
// Optional define SHA256_PAD_BYTE_SWAP_EN: input words arrive little-endian
// (byte 0 in [7:0]) and are byte-reversed on entry.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         abort_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [31:0]  in_data_i,
    input  logic [2:0]   in_nbytes_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [511:0] out_block_o,
    output logic         out_first_o,
    output logic         out_last_o
);

    pad_state_e                       state_q, state_d;
    logic [0:BLOCK_WORDS-1][31:0]     blk_q, blk_d;
    logic [3:0]                       widx_q, widx_d;
    logic [LEN_W-1:0]                 bytes_q, bytes_d, bytes_sum;
    logic                             first_q, first_d;
    logic                             pad_pend_q, pad_pend_d;
    logic                             pad80_q, pad80_d;
    logic                             in_ready_q, in_ready_d;
    logic                             out_valid_q, out_valid_d;
    logic                             out_first_q, out_first_d;
    logic                             out_last_q, out_last_d;

    logic [31:0] data_in;
    logic [31:0] last_word;
    logic [2:0]  nb;
    logic [4:0]  pidx;
    logic [63:0] len_now, len_held;

    // Bit length of a byte count, zero-extended into the 64-bit length field
    function automatic logic [63:0] len_field(input logic [LEN_W-1:0] nbytes);
        logic [LEN_W-1:0] bits;
        logic [63:0]      f;
        bits           = nbytes << 3;
        f              = '0;
        f[LEN_W-1:0]   = bits;
        return f;
    endfunction

`ifdef SHA256_PAD_BYTE_SWAP_EN
    assign data_in = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
    assign data_in = in_data_i;
`endif

    assign nb        = clamp_nbytes(in_nbytes_i);
    assign bytes_sum = bytes_q + LEN_W'(nb);
    assign len_now   = len_field(bytes_sum);
    assign len_held  = len_field(bytes_q);
    // Word index that receives the 0x80 terminator (16 = spills into next block)
    assign pidx      = (nb == 3'd4) ? ({1'b0, widx_q} + 5'd1) : {1'b0, widx_q};

    sha256_pad_word u_pad_word (
        .word_i   (data_in),
        .nbytes_i (nb),
        .word_o   (last_word)
    );

    // Next-state, buffer and output computation; abort overrides everything
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        widx_d      = widx_q;
        bytes_d     = bytes_q;
        first_d     = first_q;
        pad_pend_d  = pad_pend_q;
        pad80_d     = pad80_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;

        if (abort_i) begin
            state_d     = ST_IDLE;
            blk_d       = '0;
            widx_d      = '0;
            bytes_d     = '0;
            first_d     = 1'b1;
            pad_pend_d  = 1'b0;
            pad80_d     = 1'b0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_FILL;
                    in_ready_d = 1'b1;
                end
                ST_FILL: begin
                    if (in_valid_i && in_ready_q) begin
                        bytes_d = bytes_sum;
                        if (!in_last_i) begin
                            blk_d[widx_q] = data_in;
                            widx_d        = widx_q + 4'd1;
                            if (widx_q == 4'd15) begin
                                state_d     = ST_EMIT;
                                in_ready_d  = 1'b0;
                                out_valid_d = 1'b1;
                                out_first_d = first_q;
                                out_last_d  = 1'b0;
                            end
                        end else begin
                            blk_d[widx_q] = last_word;
                            if (nb == 3'd4 && widx_q != 4'd15) begin
                                blk_d[widx_q + 4'd1] = {PAD_BYTE, 24'h0};
                            end
                            widx_d      = '0;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                            out_first_d = first_q;
                            if (pidx <= 5'd13) begin
                                blk_d[14]   = len_now[63:32];
                                blk_d[15]   = len_now[31:0];
                                state_d     = ST_EMIT_LAST;
                                out_last_d  = 1'b1;
                            end else begin
                                state_d     = ST_EMIT;
                                out_last_d  = 1'b0;
                                pad_pend_d  = 1'b1;
                                pad80_d     = (pidx == 5'd16);
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready_i) begin
                        blk_d       = '0;
                        first_d     = 1'b0;
                        out_valid_d = 1'b0;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (pad_pend_q) begin
                            state_d    = ST_PADBLK;
                            in_ready_d = 1'b0;
                        end else begin
                            state_d    = ST_FILL;
                            in_ready_d = 1'b1;
                        end
                    end
                end
                ST_PADBLK: begin
                    blk_d       = '0;
                    blk_d[0]    = pad80_q ? {PAD_BYTE, 24'h0} : 32'h0;
                    blk_d[14]   = len_held[63:32];
                    blk_d[15]   = len_held[31:0];
                    pad_pend_d  = 1'b0;
                    pad80_d     = 1'b0;
                    state_d     = ST_EMIT_LAST;
                    out_valid_d = 1'b1;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b1;
                end
                ST_EMIT_LAST: begin
                    if (out_ready_i) begin
                        blk_d       = '0;
                        widx_d      = '0;
                        bytes_d     = '0;
                        first_d     = 1'b1;
                        state_d     = ST_FILL;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b0;
                end
            endcase
        end
    end

    // State, buffer and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            blk_q       <= '0;
            widx_q      <= '0;
            bytes_q     <= '0;
            first_q     <= 1'b1;
            pad_pend_q  <= 1'b0;
            pad80_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            widx_q      <= widx_d;
            bytes_q     <= bytes_d;
            first_q     <= first_d;
            pad_pend_q  <= pad_pend_d;
            pad80_q     <= pad80_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_block_o = blk_q;
    assign out_first_o = out_first_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: byte-level padding model feeds a
// scoreboard of expected blocks; a consumer process pops and compares.
module tb_sha256_msg_padder;

  localparam int LIMIT = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         abort_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic [2:0]   in_nbytes_i;
  logic         in_last_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [511:0] out_block_o;
  logic         out_first_o;
  logic         out_last_o;

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           cons_en = 1'b0;
  logic [7:0]   msg [0:127];
  logic [511:0] blk0;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .abort_i     (abort_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_nbytes_i (in_nbytes_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_block_o (out_block_o),
    .out_first_o (out_first_o),
    .out_last_o  (out_last_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] bus_word(input logic [7:0] b0, b1, b2, b3);
`ifdef SHA256_PAD_BYTE_SWAP_EN
    return {b3, b2, b1, b0};
`else
    return {b0, b1, b2, b3};
`endif
  endfunction

  // Consumer: takes every valid block while enabled and checks it against the scoreboard
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid_o && cons_en) begin
        exp_t e;
        chk("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("blk_data", out_block_o, e.blk);
          chk("blk_first", out_first_o, e.first);
          chk("blk_last", out_last_o, e.last);
        end
      end
      out_ready_i = cons_en;
    end
  end

  // Reference padding at byte level: message, 0x80, zeros, 64-bit length
  task automatic push_expected(input int cnt);
    logic [7:0]  pb [0:191];
    logic [63:0] len;
    exp_t        e;
    int          total;
    int          nblk;
    total = ((cnt + 9 + 63) / 64) * 64;
    nblk  = total / 64;
    for (int i = 0; i < 192; i++) pb[i] = 8'h00;
    for (int i = 0; i < cnt; i++) pb[i] = msg[i];
    pb[cnt] = 8'h80;
    len = 64'(cnt) * 64'd8;
    for (int j = 0; j < 8; j++) pb[total - 8 + j] = len[63 - 8*j -: 8];
    for (int k = 0; k < nblk; k++) begin
      for (int b = 0; b < 64; b++) e.blk[511 - 8*b -: 8] = pb[64*k + b];
      e.first = (k == 0);
      e.last  = (k == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic l);
    int waited = 0;
    in_valid_i  = 1'b1;
    in_data_i   = d;
    in_nbytes_i = n;
    in_last_i   = l;
    while (!in_ready_o && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_wait", waited < LIMIT, 1'b1);
    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  // Sends msg[0:cnt-1]; unused bytes of the last word carry junk to exercise masking
  task automatic send_msg(input int cnt, input bit odd_nb);
    int nw;
    int n;
    logic [7:0] b [4];
    logic [2:0] nbf;
    nw = (cnt == 0) ? 1 : (cnt + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      n = (w == nw - 1) ? (cnt - 4*w) : 4;
      for (int i = 0; i < 4; i++) b[i] = (i < n) ? msg[4*w + i] : 8'hEE;
      nbf = (odd_nb && w == 2 && w != nw - 1) ? 3'd7 : 3'(n);
      send_word(bus_word(b[0], b[1], b[2], b[3]), nbf, w == nw - 1);
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    chk("drain", waited < LIMIT, 1'b1);
    @(negedge clk);
  endtask

  task automatic fill_msg(input int seed);
    for (int i = 0; i < 128; i++) msg[i] = 8'(i * 3 + seed);
  endtask

  initial begin
    rst         = 1'b1;
    abort_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_nbytes_i = '0;
    in_last_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_block", out_block_o, 512'h0);
    chk("rst_first", out_first_o, 1'b0);
    chk("rst_last", out_last_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fill_in_ready", in_ready_o, 1'b1);

    // "abc": single block, one-cycle latency
    cons_en = 1'b1;
    exp_q.push_back('{blk: {32'h61626380, 448'h0, 32'h00000018}, first: 1'b1, last: 1'b1});
    send_word(bus_word(8'h61, 8'h62, 8'h63, 8'hEE), 3'd3, 1'b1);
    chk("abc_latency", out_valid_o, 1'b1);
    chk("abc_in_ready", in_ready_o, 1'b0);
    drain();

    // Empty message
    exp_q.push_back('{blk: {32'h80000000, 480'h0}, first: 1'b1, last: 1'b1});
    send_word(bus_word(8'hEE, 8'hEE, 8'hEE, 8'hEE), 3'd0, 1'b1);
    drain();

    // 55 bytes: terminator in word 13, one block (word 2 uses nbytes=7)
    fill_msg(5);
    push_expected(55);
    send_msg(55, 1'b1);
    drain();

    // 56 bytes: terminator in word 14, length-only second block
    fill_msg(9);
    push_expected(56);
    send_msg(56, 1'b0);
    drain();

    // 64 bytes: terminator spills to word 0 of the second block
    fill_msg(17);
    push_expected(64);
    send_msg(64, 1'b0);
    drain();

    // 100 bytes: 16th word emits a data block, remainder padded in block 2
    fill_msg(33);
    push_expected(100);
    send_msg(100, 1'b0);
    drain();

    // Consumer stalled 10 cycles: block held, no input accepted
    cons_en = 1'b0;
    exp_q.push_back('{blk: {32'h61626380, 448'h0, 32'h00000018}, first: 1'b1, last: 1'b1});
    send_word(bus_word(8'h61, 8'h62, 8'h63, 8'h00), 3'd3, 1'b1);
    blk0 = out_block_o;
    in_valid_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", out_valid_o, 1'b1);
      chk("stall_in_ready", in_ready_o, 1'b0);
      chk("stall_block", out_block_o, blk0);
    end
    in_valid_i = 1'b0;
    cons_en = 1'b1;
    drain();

    // Abort mid-message, then a fresh "abc" restarts with first=1 and length 0x18
    fill_msg(41);
    for (int w = 0; w < 5; w++)
      send_word(bus_word(msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]), 3'd4, 1'b0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_out_valid", out_valid_o, 1'b0);
    chk("abort_in_ready", in_ready_o, 1'b0);
    exp_q.push_back('{blk: {32'h61626380, 448'h0, 32'h00000018}, first: 1'b1, last: 1'b1});
    send_word(bus_word(8'h61, 8'h62, 8'h63, 8'h55), 3'd3, 1'b1);
    drain();

    // Abort while a block is pending discards it
    cons_en = 1'b0;
    send_word(bus_word(8'h61, 8'h62, 8'h63, 8'h00), 3'd3, 1'b1);
    chk("pend_valid", out_valid_o, 1'b1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("pend_abort_valid", out_valid_o, 1'b0);
    chk("pend_abort_block", out_block_o, 512'h0);
    cons_en = 1'b1;

    // Reset mid-message: no block until a new message completes
    for (int w = 0; w < 3; w++)
      send_word(bus_word(8'h11, 8'h22, 8'h33, 8'h44), 3'd4, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_valid", out_valid_o, 1'b0);
    chk("midrst_in_ready", in_ready_o, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_valid", out_valid_o, 1'b0);
    exp_q.push_back('{blk: {32'h61626380, 448'h0, 32'h00000018}, first: 1'b1, last: 1'b1});
    send_word(bus_word(8'h61, 8'h62, 8'h63, 8'h00), 3'd3, 1'b1);
    drain();

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
